// File: rtl/data_gen_pkg.sv
// Shared definitions for the packetised AXI-stream test data generator.
//   - data mode encodings (increment / constant / LFSR)
//   - generator FSM state encoding
//   - default Galois LFSR tap mask
package data_gen_pkg;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  // Encoding 2'd3 is reserved and behaves like MODE_CONST.

  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/data_gen_next.sv
// Combinational next-data-word function for the test data generator.
// Ports:
//   mode      in  2           data mode (MODE_INC / MODE_CONST / MODE_LFSR, 3 = const)
//   data      in  DATA_WIDTH  current data word
//   data_next out DATA_WIDTH  word that follows 'data' in the selected mode
module data_gen_next
  import data_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_STEP  = DATA_WIDTH'(32'h01010101),
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] data_next
);

  always_comb begin
    case (mode)
      MODE_INC:  data_next = data + DATA_STEP;  // wraps modulo 2^DATA_WIDTH
      // Galois form: shift right, fold the taps back in when a 1 falls out.
      MODE_LFSR: data_next = (data >> 1) ^ (data[0] ? LFSR_TAPS : '0);
      default:   data_next = data;              // constant and reserved modes
    endcase
  end

endmodule

// File: rtl/data_gen_pkt.sv
// Runtime-configurable AXI-stream test data source with packetisation.
// A start pulse in IDLE latches the configuration and streams num_samples_cfg
// beats, asserting out_last every pkt_len beats (and always on the final
// beat), inserting gap_cycles idle cycles after each packet, then pulsing done.
// Ports:
//   clock            in   system clock (rising edge)
//   reset            in   synchronous, active-high reset
//   start            in   begin a run (ignored unless idle)
//   mode             in   0 increment, 1 constant, 2 LFSR, 3 constant
//   num_samples_cfg  in   total beats in the run
//   pkt_len          in   beats per packet, 0 = one packet for the whole run
//   gap_cycles       in   idle cycles after each non-final packet
//   out_data/out_last/out_valid/out_ready  AXI-stream master
//   busy             out  run in progress
//   done             out  one-cycle pulse after the final beat is accepted
//   num_samples      out  beats accepted since the last start
module data_gen_pkt
  import data_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    SAMPLES_WIDTH = 32,
  parameter int                    PKT_WIDTH     = 16,
  parameter int                    GAP_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_START    = DATA_WIDTH'(32'h04030201),
  parameter logic [DATA_WIDTH-1:0] DATA_STEP     = DATA_WIDTH'(32'h01010101),
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = DATA_WIDTH'(32'h80200003)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [SAMPLES_WIDTH-1:0] num_samples_cfg,
  input  logic [PKT_WIDTH-1:0]     pkt_len,
  input  logic [GAP_WIDTH-1:0]     gap_cycles,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [SAMPLES_WIDTH-1:0] num_samples
);

  state_t                   state_q,   state_d;
  logic [1:0]               mode_q,    mode_d;
  logic [SAMPLES_WIDTH-1:0] cfg_num_q, cfg_num_d;
  logic [PKT_WIDTH-1:0]     cfg_pkt_q, cfg_pkt_d;
  logic [GAP_WIDTH-1:0]     cfg_gap_q, cfg_gap_d;
  logic [PKT_WIDTH-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]    data_q,    data_d;
  logic                     last_q,    last_d;
  logic                     valid_q,   valid_d;
  logic                     busy_q,    busy_d;
  logic                     done_q,    done_d;
  logic [SAMPLES_WIDTH-1:0] num_q,     num_d;

  logic [DATA_WIDTH-1:0]    data_adv;
  logic [SAMPLES_WIDTH-1:0] remaining;
  logic [PKT_WIDTH-1:0]     pkt_cnt_nxt;
  logic                     xfer;

  data_gen_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_STEP  (DATA_STEP),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_next (
    .mode      (mode_q),
    .data      (data_q),
    .data_next (data_adv)
  );

  assign xfer        = valid_q & out_ready;
  // Beats still owed, including the one currently presented.
  assign remaining   = cfg_num_q - num_q;
  // Packet-relative index of the beat after the current one; in RUN, last_q
  // set on a non-final beat means the current beat closes its packet.
  assign pkt_cnt_nxt = last_q ? '0 : pkt_cnt_q + PKT_WIDTH'(1);

  always_comb begin
    // NOTE: every next-value starts from its hold value, so no branch can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    cfg_num_d = cfg_num_q;
    cfg_pkt_d = cfg_pkt_q;
    cfg_gap_d = cfg_gap_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    last_d    = last_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    num_d     = num_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          cfg_num_d = num_samples_cfg;
          cfg_pkt_d = pkt_len;
          cfg_gap_d = gap_cycles;
          num_d     = '0;
          pkt_cnt_d = '0;
          // An all-zero LFSR would lock up, so a zero seed becomes 1.
          data_d    = (mode == MODE_LFSR && DATA_START == '0) ? DATA_WIDTH'(1) : DATA_START;
          if (num_samples_cfg == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (num_samples_cfg == SAMPLES_WIDTH'(1)) || (pkt_len == PKT_WIDTH'(1));
          end
        end
      end

      RUN: begin
        if (xfer) begin
          num_d  = num_q + SAMPLES_WIDTH'(1);
          data_d = data_adv;
          if (remaining == SAMPLES_WIDTH'(1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pkt_cnt_d = pkt_cnt_nxt;
            // out_last is precomputed for the beat that follows.
            last_d    = (remaining == SAMPLES_WIDTH'(2)) ||
                        (cfg_pkt_q != '0 && pkt_cnt_nxt == cfg_pkt_q - PKT_WIDTH'(1));
            if (last_q && cfg_gap_q != '0) begin
              state_d   = GAP;
              valid_d   = 1'b0;
              gap_cnt_d = cfg_gap_q - GAP_WIDTH'(1);
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = RUN;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments, so every register here samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_INC;
      cfg_num_q <= '0;
      cfg_pkt_q <= '0;
      cfg_gap_q <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= DATA_START;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cfg_num_q <= cfg_num_d;
      cfg_pkt_q <= cfg_pkt_d;
      cfg_gap_q <= cfg_gap_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      num_q     <= num_d;
    end
  end

  assign out_data    = data_q;
  assign out_last    = last_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign num_samples = num_q;

endmodule

// File: tb/tb_data_gen_pkt.sv
// Self-checking bench for data_gen_pkt: a table of run configurations with
// hand-derived expectations, a few random configurations, and hand-written
// reset sequences. Expected beats come from a behavioural model of the stream.
module tb_data_gen_pkt;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] num_samples_cfg;
  logic [15:0] pkt_len;
  logic [7:0]  gap_cycles;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [31:0] num_samples;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  data_gen_pkt dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .num_samples_cfg (num_samples_cfg),
    .pkt_len         (pkt_len),
    .gap_cycles      (gap_cycles),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done),
    .num_samples     (num_samples)
  );

  typedef struct {
    logic [1:0]  mode;
    int          n;
    int          p;
    int          g;
    int          ready_pct;
    bit          inject;      // pulse start with other config mid-run
    int          exp_lasts;   // -1: not checked
    int          exp_span;    // cycles first beat -> done, -1: not checked
    bit          chk_final;
    logic [31:0] final_data;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: what the word after d is in a given mode.
  function automatic logic [31:0] model_next(input logic [1:0] m, input logic [31:0] d);
    if (m == 2'd0) return d + 32'h01010101;
    if (m == 2'd2) return {1'b0, d[31:1]} ^ ((d % 2 == 1) ? 32'h80200003 : 32'h0);
    return d;
  endfunction

  task automatic run_case(input vec_t v);
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    logic [31:0] d;
    logic [31:0] prev_data;
    logic [31:0] final_seen;
    bit          prev_last, prev_stall, got_done, injected;
    int          beat, gap_left, first, lasts;

    d = 32'h04030201;
    for (int i = 0; i < v.n; i++) begin
      exp_data.push_back(d);
      exp_last.push_back((i == v.n - 1) || (v.p != 0 && (i % v.p) == v.p - 1));
      d = model_next(v.mode, d);
    end

    @(negedge clock);
    mode            = v.mode;
    num_samples_cfg = v.n;
    pkt_len         = 16'(v.p);
    gap_cycles      = 8'(v.g);
    start           = 1'b1;

    beat = 0; gap_left = 0; first = -1; lasts = 0;
    prev_stall = 0; got_done = 0; injected = 0;
    prev_data = '0; prev_last = 0; final_seen = '0;

    for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        got_done = 1;
        check("done_beats", beat, v.n);
        check("done_num_samples", num_samples, v.n);
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        if (v.exp_span >= 0) check("span", cyc - first, v.exp_span);
      end else if (beat < v.n) begin
        if (gap_left > 0) begin
          check("gap_valid_low", out_valid, 0);
          gap_left--;
        end else begin
          check("valid_high", out_valid, 1);
        end
        check("busy_run", busy, 1);
        check("num_samples_run", num_samples, beat);
        if (out_valid) begin
          if (first < 0) first = cyc;
          check("data", out_data, exp_data[beat]);
          check("last", out_last, exp_last[beat]);
          if (prev_stall) begin
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
          end
        end
      end else begin
        check("done_pulse", done, 1);
        got_done = 1;
      end

      if (!got_done) begin
        out_ready = ($urandom_range(99) < v.ready_pct);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready && beat < v.n) begin
          if (exp_last[beat] && beat != v.n - 1) gap_left = v.g;
          if (out_last) lasts++;
          final_seen = out_data;
          beat++;
        end
        if (v.inject && !injected && beat == 4) begin
          injected        = 1;
          start           = 1'b1;
          mode            = 2'd2;
          num_samples_cfg = 3;
          pkt_len         = 2;
          gap_cycles      = 5;
        end
      end
    end

    if (!got_done) check("timeout_done", 0, 1);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    if (v.exp_lasts >= 0) check("last_count", lasts, v.exp_lasts);
    if (v.chk_final) check("final_data", final_seen, v.final_data);
  endtask

  vec_t vecs[8];

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; num_samples_cfg = '0;
    pkt_len = '0; gap_cycles = '0; out_ready = 1'b0;

    // Table: mode, n, p, g, ready%, inject, lasts, span, chk_final, final
    vecs[0] = '{2'd0, 10, 0, 0, 100, 1'b0, 1, 10, 1'b1, 32'h0D0C0B0A};
    vecs[1] = '{2'd0,  7, 3, 2, 100, 1'b0, 3, 11, 1'b1, 32'h0A090807};
    vecs[2] = '{2'd2, 20, 0, 0,  50, 1'b0, 1, -1, 1'b0, 32'h0};
    vecs[3] = '{2'd0,  0, 0, 0, 100, 1'b0, 0, -1, 1'b0, 32'h0};
    vecs[4] = '{2'd0, 10, 0, 0, 100, 1'b1, 1, 10, 1'b1, 32'h0D0C0B0A};
    vecs[5] = '{2'd1,  9, 4, 1, 100, 1'b0, 3, 11, 1'b1, 32'h04030201};
    vecs[6] = '{2'd3,  5, 1, 0, 100, 1'b0, 5,  5, 1'b1, 32'h04030201};
    vecs[7] = '{2'd2, 12, 5, 3,  70, 1'b0, 3, -1, 1'b0, 32'h0};

    repeat (3) @(negedge clock);
    check("rst_data", out_data, 32'h04030201);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_num_samples", num_samples, 0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) run_case(vecs[i]);

    for (int r = 0; r < 4; r++) begin
      vec_t v;
      v.mode = 2'($urandom_range(3));
      v.n = $urandom_range(25, 1);
      v.p = $urandom_range(6);
      v.g = $urandom_range(3);
      v.ready_pct = $urandom_range(100, 30);
      v.inject = 1'b0;
      v.exp_lasts = -1;
      v.exp_span = -1;
      v.chk_final = 1'b0;
      v.final_data = '0;
      run_case(v);
    end

    // Reset in the middle of a run.
    @(negedge clock);
    mode = 2'd0; num_samples_cfg = 10; pkt_len = 0; gap_cycles = 0;
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_pre_data", out_data, 32'h08070605);
    check("mid_pre_num", num_samples, 4);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_num", num_samples, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("mid_rst_no_done", done, 0);
      check("mid_rst_idle_valid", out_valid, 0);
    end

    start = 1'b1; num_samples_cfg = 3;
    @(negedge clock);
    start = 1'b0;
    check("restart_valid", out_valid, 1);
    check("restart_data", out_data, 32'h04030201);
    @(negedge clock);
    check("restart_num", num_samples, 1);
    check("restart_data2", out_data, 32'h05040302);
    @(negedge clock);
    check("restart_last", out_last, 1);
    @(negedge clock);
    check("restart_done", done, 1);
    check("restart_num_final", num_samples, 3);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
